// File: rtl/bp_common_pkg.sv
// Shared types and helpers for the core request arbiter.
package bp_common_pkg;

    typedef enum logic [1:0] {
        e_idle,
        e_send,
        e_meta,
        e_wait
    } bp_core_req_arb_state_e;

    // A single-channel index still needs one bit so ports never collapse to zero width.
    function automatic int bp_chan_width(input int num_chan);
        return (num_chan > 1) ? $clog2(num_chan) : 1;
    endfunction

endpackage

// File: rtl/bp_core_req_arbiter_if.sv
// Upstream per-channel request/metadata bundle and downstream request port of the arbiter.
interface bp_core_req_arbiter_if
    import bp_common_pkg::*;
#(
    parameter int num_chan_p  = 2,
    parameter int req_width_p = 128,
    parameter int md_width_p  = 8
);
    localparam int chan_w_lp = bp_chan_width(num_chan_p);

    logic [num_chan_p*req_width_p-1:0] req_i;
    logic [num_chan_p-1:0]             req_v_i;
    logic [num_chan_p-1:0]             req_ready_o;
    logic [num_chan_p*md_width_p-1:0]  req_metadata_i;
    logic [num_chan_p-1:0]             req_metadata_v_i;
    logic [num_chan_p-1:0]             req_complete_o;

    logic [req_width_p-1:0]            req_o;
    logic                              req_v_o;
    logic                              req_ready_i;
    logic [md_width_p-1:0]             req_metadata_o;
    logic                              req_metadata_v_o;
    logic [chan_w_lp-1:0]              req_chan_o;
    logic                              req_complete_i;
    logic                              timeout_o;

    modport slave (
        input  req_i, req_v_i, req_metadata_i, req_metadata_v_i, req_ready_i, req_complete_i,
        output req_ready_o, req_complete_o, req_o, req_v_o, req_metadata_o, req_metadata_v_o,
               req_chan_o, timeout_o
    );

    modport master (
        output req_i, req_v_i, req_metadata_i, req_metadata_v_i, req_ready_i, req_complete_i,
        input  req_ready_o, req_complete_o, req_o, req_v_o, req_metadata_o, req_metadata_v_o,
               req_chan_o, timeout_o
    );

endinterface

// File: rtl/bp_core_req_arb_rr.sv
// Priority selector: scans valids starting at the pointer and returns a one-hot grant.
module bp_core_req_arb_rr
    import bp_common_pkg::*;
#(
    parameter int num_chan_p = 2,
    localparam int chan_w_lp = bp_chan_width(num_chan_p)
) (
    input  logic [num_chan_p-1:0] v_i,
    input  logic [chan_w_lp-1:0]  ptr_i,
    output logic [num_chan_p-1:0] grant_o
);

    logic found;
    int   idx;

    // A pointer held at zero degenerates into lowest-index-first priority.
    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        idx     = 0;
        for (int i = 0; i < num_chan_p; i++) begin
            idx = (int'(ptr_i) + i) % num_chan_p;
            if (!found && v_i[chan_w_lp'(idx)]) begin
                grant_o[chan_w_lp'(idx)] = 1'b1;
                found                    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bp_core_req_arbiter.sv
// Arbitrates cache request channels onto one downstream port, one transaction outstanding at a time.
// Optional completion watchdog is built when BP_CORE_REQ_ARB_WATCHDOG_EN is defined.
module bp_core_req_arbiter
    import bp_common_pkg::*;
#(
    parameter int num_chan_p  = 2,
    parameter int req_width_p = 128,
    parameter int md_width_p  = 8,
    parameter int rr_p        = 1,
    parameter int timeout_p   = 1024
) (
    input  logic                 clk_i,
    input  logic                 reset_i,
    bp_core_req_arbiter_if.slave bus_io
);
    localparam int chan_w_lp = bp_chan_width(num_chan_p);

    if (num_chan_p < 2 || num_chan_p > 8 || timeout_p < 1) begin : g_cfg_check
        $error("bp_core_req_arbiter: unsupported num_chan_p or timeout_p");
    end

    bp_core_req_arb_state_e state_q, state_d;

    logic [chan_w_lp-1:0]   ptr_q, ptr_d, chan_q, chan_d, win_idx, ptr_next;
    logic [req_width_p-1:0] req_q, req_d, win_req;
    logic [md_width_p-1:0]  md_q, md_d, win_md, own_md;
    logic                   md_have_q, md_have_d, win_md_v, own_md_v;
    logic [num_chan_p-1:0]  complete_q, complete_d, grant, ready, owner_oh;
    logic                   req_v, md_v;

    bp_core_req_arb_rr #(.num_chan_p(num_chan_p)) arb_rr (
        .v_i    (bus_io.req_v_i),
        .ptr_i  (ptr_q),
        .grant_o(grant)
    );

    always_comb begin
        win_idx  = '0;
        win_req  = '0;
        win_md   = '0;
        win_md_v = 1'b0;
        own_md   = '0;
        own_md_v = 1'b0;
        owner_oh = '0;
        for (int i = 0; i < num_chan_p; i++) begin
            if (grant[i]) begin
                win_idx  = chan_w_lp'(i);
                win_req  = bus_io.req_i[i*req_width_p +: req_width_p];
                win_md   = bus_io.req_metadata_i[i*md_width_p +: md_width_p];
                win_md_v = bus_io.req_metadata_v_i[i];
            end
            if (chan_q == chan_w_lp'(i)) begin
                owner_oh[i] = 1'b1;
                own_md      = bus_io.req_metadata_i[i*md_width_p +: md_width_p];
                own_md_v    = bus_io.req_metadata_v_i[i];
            end
        end
    end

    assign ptr_next = (win_idx == chan_w_lp'(num_chan_p - 1)) ? '0 : win_idx + chan_w_lp'(1);

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        req_d      = req_q;
        chan_d     = chan_q;
        md_d       = md_q;
        md_have_d  = md_have_q;
        complete_d = '0;
        ready      = '0;
        req_v      = 1'b0;
        md_v       = 1'b0;
        case (state_q)
            e_idle: begin
                if (!reset_i) begin
                    ready = grant;
                end
                if (|ready) begin
                    state_d   = e_send;
                    req_d     = win_req;
                    chan_d    = win_idx;
                    md_have_d = win_md_v;
                    if (win_md_v) begin
                        md_d = win_md;
                    end
                    if (rr_p != 0) begin
                        ptr_d = ptr_next;
                    end
                end
            end
            e_send: begin
                req_v = 1'b1;
                if (bus_io.req_ready_i) begin
                    state_d = e_meta;
                end
            end
            e_meta: begin
                if (md_have_q) begin
                    md_v    = 1'b1;
                    state_d = e_wait;
                end
            end
            e_wait: begin
                if (bus_io.req_complete_i) begin
                    complete_d = owner_oh;
                    state_d    = e_idle;
                end
            end
            default: state_d = e_idle;
        endcase
        // Only the first metadata pulse after the accept is kept.
        if (state_q != e_idle && !md_have_q && own_md_v) begin
            md_d      = own_md;
            md_have_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= e_idle;
            ptr_q      <= '0;
            req_q      <= '0;
            chan_q     <= '0;
            md_q       <= '0;
            md_have_q  <= 1'b0;
            complete_q <= '0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            req_q      <= req_d;
            chan_q     <= chan_d;
            md_q       <= md_d;
            md_have_q  <= md_have_d;
            complete_q <= complete_d;
        end
    end

    assign bus_io.req_ready_o      = ready;
    assign bus_io.req_complete_o   = complete_q;
    assign bus_io.req_o            = req_q;
    assign bus_io.req_v_o          = req_v;
    assign bus_io.req_metadata_o   = md_q;
    assign bus_io.req_metadata_v_o = md_v;
    assign bus_io.req_chan_o       = chan_q;

`ifdef BP_CORE_REQ_ARB_WATCHDOG_EN
    logic [31:0] wd_q, wd_d;
    logic        timeout_q, timeout_d;

    // Counts edges spent in e_wait; saturates at the limit and the error flag is sticky.
    always_comb begin
        wd_d      = wd_q;
        timeout_d = timeout_q;
        if (state_q != e_wait && state_d == e_wait) begin
            wd_d = '0;
        end else if (state_q == e_wait && wd_q != 32'(timeout_p)) begin
            wd_d = wd_q + 32'd1;
        end
        if (wd_d == 32'(timeout_p)) begin
            timeout_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wd_q      <= '0;
            timeout_q <= 1'b0;
        end else begin
            wd_q      <= wd_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus_io.timeout_o = timeout_q;
`else
    assign bus_io.timeout_o = 1'b0;
`endif

endmodule

// File: doc/bp_core_req_arbiter.md
BP_CORE_REQ_ARBITER -- requirements
Module: bp_core_req_arbiter

Interface
REQ-001 Parameter num_chan_p, default 2, SHALL set the number of requesting cache channels (2..8).
REQ-002 Parameter req_width_p, default 128, SHALL set the packed cache request width per channel.
REQ-003 Parameter md_width_p, default 8, SHALL set the request metadata width per channel.
REQ-004 Parameter rr_p, default 1, SHALL select round-robin (1) or fixed, lowest-index-first (0) priority.
REQ-005 Parameter timeout_p, default 1024, SHALL set the completion watchdog limit in cycles.
REQ-006 Clock and reset SHALL be: clk_i input 1, the single clock; reset_i input 1, asynchronous, active-high.
REQ-007 req_i input num_chan_p*req_width_p SHALL carry the per-channel requests; req_v_i input num_chan_p carries the valids.
REQ-008 req_ready_o output num_chan_p SHALL be the per-channel ready.
REQ-009 req_metadata_i input num_chan_p*md_width_p and req_metadata_v_i input num_chan_p SHALL carry per-channel metadata.
REQ-010 req_complete_o output num_chan_p SHALL carry the per-channel one-cycle completion pulse.
REQ-011 req_o output req_width_p, req_v_o output 1 and req_ready_i input 1 SHALL form the downstream request port.
REQ-012 req_metadata_o output md_width_p and req_metadata_v_o output 1 SHALL carry the downstream metadata.
REQ-013 req_chan_o output max(1,$clog2(num_chan_p)) SHALL give the owning channel; req_complete_i input 1 gives downstream completion.
REQ-014 timeout_o output 1 SHALL flag a sticky watchdog error.

Function
REQ-015 The FSM SHALL have the states e_idle, e_send, e_meta and e_wait.
REQ-016 In e_idle, req_ready_o SHALL be one-hot on the arbitration winner among the asserted req_v_i bits, and zero if no bit is asserted.
REQ-017 An accept (req_v_i & req_ready_o) SHALL register the request and channel and move the FSM to e_send the next cycle.
REQ-018 In e_send, req_v_o SHALL be 1; on req_v_o & req_ready_i the FSM SHALL go to e_meta.
REQ-019 Metadata SHALL be captured from the owning channel when req_metadata_v_i is asserted in any cycle from the accept cycle onward; later pulses SHALL be ignored.
REQ-020 In e_meta with metadata captured, req_metadata_v_o SHALL pulse for exactly one cycle, then the FSM SHALL go to e_wait.
REQ-021 In e_wait, req_complete_i SHALL produce a one-cycle req_complete_o[owner] pulse in the next cycle, and the FSM SHALL return to e_idle.
REQ-022 req_complete_i outside e_wait SHALL be ignored.
REQ-023 Only one request SHALL be outstanding; all req_ready_o bits SHALL be 0 outside e_idle.
REQ-024 When rr_p=1, the priority pointer SHALL advance to owner+1 (mod num_chan_p) on each accept, and SHALL not change without an accept.
REQ-025 req_chan_o and req_o SHALL hold stable from accept until return to e_idle.

Reset
REQ-026 Reset SHALL asynchronously force e_idle, the pointer to 0, timeout_o=0, the watchdog to 0, and all valid, ready and complete outputs to 0.
REQ-027 Reset asserted mid-transaction SHALL discard the transaction without producing a completion pulse.

Configuration
REQ-028 When BP_CORE_REQ_ARB_WATCHDOG_EN is defined, a counter SHALL count the cycles spent in e_wait, clear on entry to e_wait, and set timeout_o when it reaches timeout_p.
REQ-029 When BP_CORE_REQ_ARB_WATCHDOG_EN is not defined, the counter SHALL be absent and timeout_o SHALL be tied to 0.

Structure
REQ-030 The state enum bp_core_req_arb_state_e and the channel-index width function SHALL live in bp_common_pkg.
REQ-031 The priority selection SHALL be one sub-module, bp_core_req_arb_rr, which takes the valids and the pointer and returns a one-hot grant.

Verification
REQ-032 Single request: ch1 valid alone, req_ready_i=1 -> req_v_o 1 cycle after accept, req_chan_o=1, metadata pulse, completion on req_complete_o[1] 1 cycle after req_complete_i.
REQ-033 Round-robin fairness: num_chan_p=4, all valid continuously -> grant order 0,1,2,3,0.
REQ-034 Fixed priority: rr_p=0, ch0 and ch2 valid continuously -> ch0 wins every time.
REQ-035 Backpressure: req_ready_i=0 for 5 cycles -> req_v_o held 5 cycles with req_o unchanged; metadata arriving on the accept cycle is still forwarded.
REQ-036 Reset in e_wait -> all outputs 0 next edge, no req_complete_o pulse, next accept goes to pointer 0.
REQ-037 Watchdog: macro defined, timeout_p=16, no completion -> timeout_o=1 after 16 cycles in e_wait and stays 1 until reset.
